// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and constants for the restoring divider.
package div_pkg;
   localparam int WIDTH_DEF = 32;
   localparam logic DBZ_FILL = 1'b1;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/div_restoring_if.sv
// div_restoring_if: operand and result valid/ready handshakes of the divider.
interface div_restoring_if import div_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   modport master (output in_valid, dividend, divisor, out_ready,
                   input in_ready, out_valid, quotient, remainder, div_by_zero);
   modport slave (input in_valid, dividend, divisor, out_ready,
                  output in_ready, out_valid, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_sub_unit.sv
// div_sub_unit: ripple-borrow subtractor, diff = a - b with borrow out.
module div_sub_unit #(parameter int W = 33) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);
   logic [W:0] c;
   assign c[0] = 1'b0;
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign diff_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & c[i]);
   end
   assign borrow_o = c[W];
endmodule

// File: rtl/div_restoring.sv
// div_restoring: multi-cycle unsigned restoring divider, one quotient bit per cycle.
module div_restoring import div_pkg::*; #(
   parameter int  WIDTH = WIDTH_DEF,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic             clk,
   input logic             rst,
   div_restoring_if.slave  bus
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   res_quo_q, res_quo_d;
   logic [WIDTH-1:0]   res_rem_q, res_rem_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH:0]     shifted, trial;
   logic               borrow;
   assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   div_sub_unit #(.W(WIDTH + 1)) u_sub (
      .a_i      (shifted),
      .b_i      ({1'b0, dvs_q}),
      .diff_o   (trial),
      .borrow_o (borrow)
   );
   assign bus.in_ready    = state_q == IDLE;
   assign bus.out_valid   = state_q == DONE;
   assign bus.quotient    = res_quo_q;
   assign bus.remainder   = res_rem_q;
   assign bus.div_by_zero = dbz_q;
   // Result registers are separate so outputs hold the last result while the next division runs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      res_quo_d = res_quo_q;
      res_rem_d = res_rem_q;
      dbz_d     = dbz_q;
      if (state_q == IDLE && bus.in_valid) begin
         if (bus.divisor == '0) begin
            state_d   = DONE;
            res_quo_d = {WIDTH{DBZ_FILL}};
            res_rem_d = bus.dividend;
            dbz_d     = 1'b1;
         end else begin
            state_d = BUSY;
            dvs_d   = bus.divisor;
            quo_d   = bus.dividend;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
         end
      end else if (state_q == BUSY) begin
         rem_d = borrow ? shifted : trial;
         quo_d = {quo_q[WIDTH-2:0], ~borrow};
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            state_d   = DONE;
            res_quo_d = quo_d;
            res_rem_d = rem_d[WIDTH-1:0];
            dbz_d     = 1'b0;
         end
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         res_quo_q <= '0;
         res_rem_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         res_quo_q <= res_quo_d;
         res_rem_q <= res_rem_d;
         dbz_q     <= dbz_d;
      end
   end
   // Partial remainder stays below the divisor, so its top bit is never set.
   assert property (@(posedge clk) disable iff (rst) !rem_q[WIDTH]);
endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring: directed vector table, corner sequences and randomized
// producer/consumer traffic checked against plain integer division.
module tb_div_restoring;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   div_restoring_if #(.WIDTH(32)) bus ();
   div_restoring #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
   } vec_t;
   vec_t tbl [10];
   int checks = 0;
   int errors = 0;
   logic [31:0] q, r;
   logic        z;
   int          lat;
   int          acc_n = 0;
   int          res_n = 0;
   logic [31:0] qa [$];
   logic [31:0] qb [$];
   logic [31:0] pa, pb;
   int          pw;
   logic [31:0] ca, cb, cq, cr, hq, hr;
   logic        hz, stalled;
   int          cyc;
   task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] oq, output logic [31:0] orr,
                         output logic oz, output int olat);
      int w;
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      olat = 0;
      do begin
         @(negedge clk);
         olat++;
      end while (!bus.out_valid && olat < 200);
      oq  = bus.quotient;
      orr = bus.remainder;
      oz  = bus.div_by_zero;
   endtask
   task automatic take_result(input string n, input logic [31:0] eq);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk({n, "_ov_fall"}, bus.out_valid, 1'b0);
      chk({n, "_in_rdy"}, bus.in_ready, 1'b1);
      chk({n, "_hold_q"}, bus.quotient, eq);
   endtask
   initial begin
      tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
      tbl[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
      tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33};
      tbl[3] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1};
      tbl[4] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33};
      tbl[5] = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 33};
      tbl[6] = '{32'd1, 32'd2, 32'd0, 32'd1, 1'b0, 33};
      tbl[7] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1};
      tbl[8] = '{32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0, 33};
      tbl[9] = '{32'd1_000_000, 32'd1000, 32'd1000, 32'd0, 1'b0, 33};
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_quotient", bus.quotient, 32'd0);
      chk("rst_remainder", bus.remainder, 32'd0);
      chk("rst_dbz", bus.div_by_zero, 1'b0);
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].a, tbl[i].b, q, r, z, lat);
         chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("v%0d_q", i), q, tbl[i].q);
         chk($sformatf("v%0d_r", i), r, tbl[i].r);
         chk($sformatf("v%0d_dbz", i), z, tbl[i].z);
         take_result($sformatf("v%0d", i), tbl[i].q);
      end
      run_op(32'd3, 32'd10, q, r, z, lat);
      chk("stall_q", q, 32'd0);
      chk("stall_r", r, 32'd3);
      bus.in_valid = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d", i),
             {bus.out_valid, bus.in_ready, bus.div_by_zero, bus.quotient, bus.remainder},
             {3'b100, 32'd0, 32'd3});
      end
      bus.in_valid = 1'b0;
      take_result("stall", 32'd0);
      @(negedge clk);
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", bus.in_ready, 1'b1);
      chk("abort_out_valid", bus.out_valid, 1'b0);
      run_op(32'd1000, 32'd3, q, r, z, lat);
      chk("after_abort_lat", lat, 33);
      chk("after_abort_q", q, 32'd333);
      chk("after_abort_r", r, 32'd1);
      take_result("after_abort", 32'd333);
      fork
         begin
            for (int k = 0; k < 200; k++) begin
               pa = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
               pb = ($urandom_range(0, 11) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               @(negedge clk);
               bus.dividend = pa;
               bus.divisor  = pb;
               bus.in_valid = 1'b1;
               pw = 0;
               while (!bus.in_ready && pw < 1000) begin
                  @(negedge clk);
                  pw++;
               end
               if (pw >= 1000) begin
                  chk("rand_accept_timeout", pw, 0);
                  bus.in_valid = 1'b0;
                  break;
               end
               @(posedge clk);
               qa.push_back(pa);
               qb.push_back(pb);
               acc_n++;
               #1 bus.in_valid = 1'b0;
            end
         end
         begin
            cyc = 0;
            stalled = 1'b0;
            while (res_n < 200 && cyc < 30000) begin
               @(negedge clk);
               cyc++;
               if (stalled)
                  chk("rand_stall_hold",
                      {bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder},
                      {1'b1, hz, hq, hr});
               bus.out_ready = $urandom_range(0, 2) != 0;
               stalled = 1'b0;
               if (bus.out_valid) begin
                  if (!bus.out_ready) begin
                     stalled = 1'b1;
                     hq = bus.quotient;
                     hr = bus.remainder;
                     hz = bus.div_by_zero;
                  end else if (qa.size() == 0) begin
                     chk("rand_unexpected_result", 1'b1, 1'b0);
                     res_n++;
                  end else begin
                     ca = qa.pop_front();
                     cb = qb.pop_front();
                     cq = bus.quotient;
                     cr = bus.remainder;
                     res_n++;
                     if (cb == 0) begin
                        chk("rand_dbz_q", cq, 32'hFFFF_FFFF);
                        chk("rand_dbz_r", cr, ca);
                        chk("rand_dbz_flag", bus.div_by_zero, 1'b1);
                     end else begin
                        chk("rand_q", cq, ca / cb);
                        chk("rand_r", cr, ca % cb);
                        chk("rand_dbz_flag", bus.div_by_zero, 1'b0);
                        chk("rand_identity", 64'(cq) * 64'(cb) + 64'(cr), 64'(ca));
                        chk("rand_r_lt_d", cr < cb, 1'b1);
                     end
                  end
               end
            end
            bus.out_ready = 1'b0;
            if (cyc >= 30000) chk("rand_result_timeout", res_n, 200);
         end
      join
      chk("rand_accepts", acc_n, 200);
      chk("rand_results_eq_accepts", res_n, acc_n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
